// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encoding, access-length codes and the default IO base.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IF_RD  = 2'd1,
        S_LSB_RD = 2'd2,
        S_LSB_WR = 2'd3
    } state_e;

    localparam logic [1:0]  LEN_B = 2'd0;
    localparam logic [1:0]  LEN_H = 2'd1;
    localparam logic [1:0]  LEN_W = 2'd2;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Length code 3 is illegal and behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter for instruction fetch and the load/store buffer.
// Optional MEM_CTRL_IO_STALL_EN holds off IO stores while the UART TX buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lsb_req,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata
);

    state_e                state_q;
    logic [2:0]            cnt_q;
    logic [2:0]            n_q;
    logic [31:0]           buf_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic                  mem_wr_q;
    logic                  if_done_q;
    logic                  lsb_done_q;
    logic [31:0]           if_data_q;
    logic [31:0]           lsb_rdata_q;

    logic [2:0]  cnt_d;
    logic        last;
    logic [4:0]  rd_sel;
    logic [4:0]  wr_sel;
    logic [31:0] buf_d;
    logic        io_stall;
    logic        req_open;
    logic        take_wr;
    logic        take_rd;
    logic        take_if;

    always_comb begin
        cnt_d  = cnt_q + 3'd1;
        last   = (cnt_d == n_q);
        rd_sel = {cnt_q[1:0], 3'b000};
        wr_sel = {cnt_d[1:0], 3'b000};
        buf_d  = buf_q;
        buf_d[rd_sel +: 8] = mem_din;
    end

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = io_buffer_full && (lsb_addr >= ADDR_WIDTH'(IO_BASE));
`else
    logic unused_io;
    assign unused_io = io_buffer_full & (lsb_addr >= ADDR_WIDTH'(IO_BASE));
    assign io_stall  = 1'b0;
`endif

    // A done pulse in flight masks the still-held request so it is not taken twice.
    // A stalled IO store keeps lsb_req high, which also keeps IF off the port.
    assign req_open = (state_q == S_IDLE) && !if_done_q && !lsb_done_q;
    assign take_wr  = req_open && lsb_req && lsb_wr && !io_stall;
    assign take_rd  = req_open && lsb_req && !lsb_wr && !clear;
    assign take_if  = req_open && !lsb_req && if_req && !clear;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            n_q         <= 3'd0;
            buf_q       <= 32'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q    <= 3'd0;
                    buf_q    <= 32'd0;
                    mem_wr_q <= 1'b0;
                    if (take_wr) begin
                        state_q    <= S_LSB_WR;
                        mem_a_q    <= lsb_addr;
                        mem_dout_q <= lsb_wdata[7:0];
                        mem_wr_q   <= 1'b1;
                        n_q        <= len_bytes(lsb_len);
                    end else if (take_rd) begin
                        state_q <= S_LSB_RD;
                        mem_a_q <= lsb_addr;
                        n_q     <= len_bytes(lsb_len);
                    end else if (take_if) begin
                        state_q <= S_IF_RD;
                        mem_a_q <= if_addr;
                        n_q     <= 3'd4;
                    end
                end
                S_IF_RD, S_LSB_RD: begin
                    if (clear) begin
                        state_q <= S_IDLE;
                    end else begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                        if (last) begin
                            state_q <= S_IDLE;
                            if (state_q == S_IF_RD) begin
                                if_done_q <= 1'b1;
                                if_data_q <= buf_d;
                            end else begin
                                lsb_done_q  <= 1'b1;
                                lsb_rdata_q <= buf_d;
                            end
                        end else begin
                            mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_LSB_WR: begin
                    // Committed stores ignore clear and always run to the last byte.
                    if (last) begin
                        state_q    <= S_IDLE;
                        mem_wr_q   <= 1'b0;
                        lsb_done_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_d;
                        mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
                        mem_dout_q <= lsb_wdata[wr_sel +: 8];
                    end
                end
            endcase
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized 1/2/4-byte accesses
// against a byte-addressed RAM model; covers MEM_CTRL_IO_STALL_EN when defined.
`timescale 1ns/1ps
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_wr, lsb_done;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    int vectors    = 0;
    int miscompares = 0;
    int both_hi    = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_WIDTH(32), .IO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .lsb_req(lsb_req), .lsb_wr(lsb_wr),
        .lsb_len(lsb_len), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    // RAM model: sparse written bytes over a fixed address-derived background pattern.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t wq[$];

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        if (rdy_in && mem_wr) wq.push_back('{mem_a, mem_dout});
    end

    always @(negedge clk_in) begin
        mem_din = rd(mem_a);
        if (if_done && lsb_done) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind 0 = IF fetch, 1 = LSB load, 2 = LSB store. Starts and ends just after a falling edge.
    task automatic txn(input int kind, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall_at, input int clr_at,
                       input string tag);
        int n, cyc, rc, exp_lat;
        logic [31:0] exp_rd;
        logic addr_ok, done, was_rdy;
        n = (kind == 0) ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        exp_rd = 32'd0;
        for (int k = 0; k < n; k++) exp_rd |= 32'(rd(addr + 32'(k))) << (8 * k);
        wq.delete();
        if (kind == 0) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            lsb_req = 1'b1; lsb_wr = (kind == 2); lsb_len = len; lsb_addr = addr; lsb_wdata = wd;
        end
        cyc = 0; rc = 0; addr_ok = 1'b1; done = 1'b0;
        while (!done && cyc < 40) begin
            was_rdy = rdy_in;
            @(negedge clk_in);
            cyc++;
            rc += int'(was_rdy);
            if (rc >= 1 && rc <= n && mem_a !== addr + 32'(rc - 1)) addr_ok = 1'b0;
            done = (kind == 0) ? if_done : lsb_done;
            if (!done) begin
                if (cyc == stall_at)     rdy_in = 1'b0;
                if (cyc == stall_at + 3) rdy_in = 1'b1;
                if (cyc == clr_at)       clear  = 1'b1;
                if (cyc == clr_at + 2)   clear  = 1'b0;
            end
        end
        exp_lat = n + 1 + ((stall_at > 0) ? 3 : 0);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
        if (kind == 0) chk({tag, "_if_data"}, if_data, exp_rd);
        if (kind == 1) chk({tag, "_lsb_rdata"}, lsb_rdata, exp_rd);
        if (kind == 2) begin
            chk({tag, "_wr_cycles"}, 32'(wq.size()), 32'(n));
            for (int k = 0; k < n; k++) begin
                if (k < wq.size()) begin
                    chk({tag, "_wr_addr"}, wq[k].a, addr + 32'(k));
                    chk({tag, "_wr_byte"}, 32'(wq[k].d), 32'(wd[8*k +: 8]));
                end
            end
        end
        if_req = 1'b0; lsb_req = 1'b0; clear = 1'b0; rdy_in = 1'b1;
        @(negedge clk_in);
        chk({tag, "_pulse_len"}, 32'(if_done | lsb_done), 32'd0);
    endtask

    initial begin
        int cyc, lcyc, icyc, bad;
        logic [31:0] exp_l, exp_i, a0;
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = 2'd0;
        lsb_addr = 32'd0; lsb_wdata = 32'd0;
        repeat (3) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_ctl", {28'd0, mem_wr, if_done, lsb_done, 1'b0}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // 1: IF word fetch from known bytes
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        txn(0, 2'd2, 32'h100, 32'd0, -1, -1, "t1");
        chk("t1_word", if_data, 32'h4433_2211);

        // 2: simultaneous requests, LSB half load wins
        exp_l = {16'd0, rd(32'h203), rd(32'h202)};
        exp_i = {rd(32'h503), rd(32'h502), rd(32'h501), rd(32'h500)};
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd1; lsb_addr = 32'h202;
        if_req = 1'b1; if_addr = 32'h500;
        cyc = 0; lcyc = 0; icyc = 0;
        while (icyc == 0 && cyc < 30) begin
            @(negedge clk_in);
            cyc++;
            if (lsb_done) begin
                lcyc = cyc; lsb_req = 1'b0;
                chk("t2_lsb_rdata", lsb_rdata, exp_l);
            end
            if (if_done) begin
                icyc = cyc; if_req = 1'b0;
                chk("t2_if_data", if_data, exp_i);
            end
        end
        chk("t2_lsb_done_cycle", 32'(lcyc), 32'd3);
        chk("t2_if_done_cycle", 32'(icyc), 32'd9);
        @(negedge clk_in);

        // 3: word store
        txn(2, 2'd2, 32'h300, 32'hDEAD_BEEF, -1, -1, "t3");

        // 4a: clear aborts an IF read; nothing completes, then a fresh fetch works
        if_req = 1'b1; if_addr = 32'h680;
        @(negedge clk_in);
        clear = 1'b1; if_req = 1'b0;
        @(negedge clk_in);
        clear = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (if_done || lsb_done || mem_wr) bad++;
        end
        chk("t4_clear_abort", 32'(bad), 32'd0);
        txn(0, 2'd2, 32'h680, 32'd0, -1, -1, "t4_refetch");

        // 4b: clear during a store is ignored
        txn(2, 2'd2, 32'h400, 32'h0102_0304, -1, 1, "t4_store_clear");

        // 5: freeze mid-read
        txn(0, 2'd2, 32'h1234, 32'd0, 2, -1, "t5_stall");

        // 6: IO store vs. full TX buffer
`ifdef MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b1;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h7E;
        if_req = 1'b1; if_addr = 32'h800;
        wq.delete(); a0 = mem_a; bad = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (mem_wr || if_done || lsb_done || mem_a !== a0) bad++;
        end
        chk("t6_port_idle", 32'(bad), 32'd0);
        io_buffer_full = 1'b0; cyc = 0;
        while (!lsb_done && cyc < 20) begin @(negedge clk_in); cyc++; end
        chk("t6_store_latency", 32'(cyc), 32'd2);
        chk("t6_wr_cycles", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("t6_wr_byte", {wq[0].a[23:0], wq[0].d}, {24'h03_0000, 8'h7E});
        lsb_req = 1'b0; cyc = 0;
        while (!if_done && cyc < 20) begin @(negedge clk_in); cyc++; end
        chk("t6_if_after", 32'(cyc), 32'd6);
        if_req = 1'b0;
        @(negedge clk_in);
`else
        io_buffer_full = 1'b1;
        txn(2, 2'd0, 32'h0003_0000, 32'h7E, -1, -1, "t6_no_stall");
        io_buffer_full = 1'b0;
`endif

        // boundaries: address wrap, illegal length code, unaligned half
        txn(1, 2'd2, 32'hFFFF_FFFE, 32'd0, -1, -1, "wrap_load");
        txn(2, 2'd3, 32'hFFFF_FFFF, 32'hCAFE_F00D, -1, -1, "len3_store_wrap");
        txn(1, 2'd1, 32'h1FF, 32'd0, -1, -1, "unaligned_half");

        for (int i = 0; i < 40; i++) begin
            int kind, sel, st, cl;
            logic [1:0]  len;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 2));
            len  = 2'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 3));
            addr = (sel == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                              : 32'($urandom_range(0, 32'h2_FFF0));
            st = ($urandom_range(0, 3) == 0) ? 1 : -1;
            cl = (kind == 2 && $urandom_range(0, 1) == 1) ? 1 : -1;
            txn(kind, len, addr, $urandom, st, cl, "rnd");
        end

        chk("dones_exclusive", 32'(both_hi), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
